// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding-select unit for the in-order integer pipeline.
// Tracks in-flight register writers from EX to write-back and resolves ID source operands.
module hazard_scoreboard #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned SEL_W    = $clog2(DEPTH + 1),
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bypass_en,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wr,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              hold,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int unsigned IW = $clog2(DEPTH + 1);

  logic              ent_valid [1:DEPTH];
  logic [REG_AW-1:0] ent_dest  [1:DEPTH];
  logic [SEL_W-1:0]  ent_rdy   [1:DEPTH];

  logic              hazard_a;
  logic              hazard_b;
  logic              found_a;
  logic              found_b;
  logic [SEL_W-1:0]  sel_a;
  logic [SEL_W-1:0]  sel_b;
  logic              ins_valid;
  logic [SEL_W-1:0]  ins_rdy;

  // Youngest-writer lookup: scanning from k=1 upward and latching the first hit.
  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    found_a  = 1'b0;
    found_b  = 1'b0;
    sel_a    = '0;
    sel_b    = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (!found_a && id_valid && id_use_rs && (id_rs != '0) &&
          ent_valid[IW'(k)] && (ent_dest[IW'(k)] == id_rs)) begin
        found_a = 1'b1;
        if (bypass_en && (SEL_W'(k) >= ent_rdy[IW'(k)])) begin
          sel_a = SEL_W'(k);
        end else begin
          hazard_a = 1'b1;
        end
      end
      if (!found_b && id_valid && id_use_rt && (id_rt != '0) &&
          ent_valid[IW'(k)] && (ent_dest[IW'(k)] == id_rt)) begin
        found_b = 1'b1;
        if (bypass_en && (SEL_W'(k) >= ent_rdy[IW'(k)])) begin
          sel_b = SEL_W'(k);
        end else begin
          hazard_b = 1'b1;
        end
      end
    end
  end

  assign stall     = id_valid & ~flush & (hazard_a | hazard_b);
  assign fwd_sel_a = sel_a;
  assign fwd_sel_b = sel_b;

  // Stalled or flushed instructions, and writes to r0, enter EX as bubbles.
  assign ins_valid = id_valid & id_wr & ~stall & ~flush & (id_dest != '0);
  assign ins_rdy   = id_is_load ? SEL_W'(1 + LOAD_LAT) : SEL_W'(1);

  // Writer tracker: shifts one stage per unfrozen cycle, oldest entry retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        ent_valid[IW'(k)] <= 1'b0;
        ent_dest[IW'(k)]  <= '0;
        ent_rdy[IW'(k)]   <= '0;
      end
    end else if (!hold) begin
      ent_valid[1] <= ins_valid;
      ent_dest[1]  <= id_dest;
      ent_rdy[1]   <= ins_rdy;
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        ent_valid[IW'(k)] <= ent_valid[IW'(k - 1)];
        ent_dest[IW'(k)]  <= ent_dest[IW'(k - 1)];
        ent_rdy[IW'(k)]   <= ent_rdy[IW'(k - 1)];
      end
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed ID streams push expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_scoreboard;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              bypass_en;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_dest;
  logic              id_wr;
  logic              id_is_load;
  logic              flush;
  logic              hold;
  logic              stall;
  logic [SEL_W-1:0]  fwd_sel_a;
  logic [SEL_W-1:0]  fwd_sel_b;
  logic [CNT_W-1:0]  stall_count;

  typedef struct {
    logic             st;
    logic [SEL_W-1:0] a;
    logic [SEL_W-1:0] b;
    logic [CNT_W-1:0] cnt;
    string            nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  hazard_scoreboard #(
    .REG_AW(REG_AW), .DEPTH(3), .LOAD_LAT(1), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .bypass_en(bypass_en), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dest(id_dest), .id_wr(id_wr), .id_is_load(id_is_load), .flush(flush),
    .hold(hold), .stall(stall), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so every pushed cycle is sampled at negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        n_checks++;
        if ({stall, fwd_sel_a, fwd_sel_b, stall_count} !==
            {mon_e.st, mon_e.a, mon_e.b, mon_e.cnt}) begin
          n_fail++;
          $display("FAIL %s: got stall=%0d sel_a=%0d sel_b=%0d cnt=%0d, expected stall=%0d sel_a=%0d sel_b=%0d cnt=%0d",
                   mon_e.nm, stall, fwd_sel_a, fwd_sel_b, stall_count,
                   mon_e.st, mon_e.a, mon_e.b, mon_e.cnt);
        end
      end
    end
  end

  task automatic set_id(input logic v, input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                        input logic [REG_AW-1:0] dest, input logic wr, input logic ld);
    id_valid   = v;
    id_rs      = rs;
    id_rt      = rt;
    id_use_rs  = 1'b1;
    id_use_rt  = 1'b1;
    id_dest    = dest;
    id_wr      = wr;
    id_is_load = ld;
  endtask

  // Push the expectation for the current cycle, then move to the next cycle.
  task automatic chk(input logic st, input logic [SEL_W-1:0] a, input logic [SEL_W-1:0] b,
                     input logic [CNT_W-1:0] cnt, input string nm);
    exp_t e;
    e.st  = st;
    e.a   = a;
    e.b   = b;
    e.cnt = cnt;
    e.nm  = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bypass_en = 1'b1;
    flush     = 1'b0;
    hold      = 1'b0;
    set_id(1'b0, '0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk(1'b0, 2'd0, 2'd0, 4'd0, "reset_idle");

    // ALU producer, immediate consumer, then a consumer one stage later
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);  chk(1'b0, 2'd0, 2'd0, 4'd0, "alu_prod");
    set_id(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0);  chk(1'b0, 2'd1, 2'd1, 4'd0, "alu_fwd1");
    set_id(1'b1, 5'd3, 5'd1, 5'd10, 1'b1, 1'b0); chk(1'b0, 2'd2, 2'd0, 4'd0, "alu_fwd2");

    // Youngest writer wins over an older load to the same register
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);  chk(1'b0, 2'd0, 2'd0, 4'd0, "young_lw");
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);  chk(1'b0, 2'd0, 2'd0, 4'd0, "young_add");
    set_id(1'b1, 5'd3, 5'd3, 5'd11, 1'b1, 1'b0); chk(1'b0, 2'd1, 2'd1, 4'd0, "young_wins");

    // Load-use: one stall cycle, then forward from stage 2
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);  chk(1'b0, 2'd0, 2'd0, 4'd0, "lw_prod");
    set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);  chk(1'b1, 2'd0, 2'd0, 4'd0, "lw_use_stall");
    chk(1'b0, 2'd2, 2'd0, 4'd1, "lw_use_fwd");

    // Writes to r0 never create an entry
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);  chk(1'b0, 2'd0, 2'd0, 4'd0, "r0_prod");
    set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);  chk(1'b0, 2'd0, 2'd0, 4'd0, "r0_use");

    // Bypass off: back-to-back dependency stalls for DEPTH cycles
    do_reset();
    bypass_en = 1'b0;
    set_id(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0);  chk(1'b0, 2'd0, 2'd0, 4'd0, "nobyp_prod");
    set_id(1'b1, 5'd2, 5'd2, 5'd8, 1'b1, 1'b0);  chk(1'b1, 2'd0, 2'd0, 4'd0, "nobyp_st1");
    chk(1'b1, 2'd0, 2'd0, 4'd1, "nobyp_st2");
    chk(1'b1, 2'd0, 2'd0, 4'd2, "nobyp_st3");
    chk(1'b0, 2'd0, 2'd0, 4'd3, "nobyp_go");

    // Flushed producer leaves no entry; flush beats a live hazard
    do_reset();
    flush = 1'b1;
    set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);  chk(1'b0, 2'd0, 2'd0, 4'd0, "flush_prod");
    flush = 1'b0;
    set_id(1'b1, 5'd9, 5'd9, 5'd12, 1'b1, 1'b0); chk(1'b0, 2'd0, 2'd0, 4'd0, "flush_use");
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);  chk(1'b0, 2'd0, 2'd0, 4'd0, "flush_lw");
    flush = 1'b1;
    set_id(1'b1, 5'd5, 5'd5, 5'd13, 1'b1, 1'b0); chk(1'b0, 2'd0, 2'd0, 4'd0, "flush_dominates");
    flush = 1'b0;
    chk(1'b0, 2'd2, 2'd2, 4'd0, "flush_after");

    // Hold freezes the tracker: load-use stall persists through the freeze
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1);  chk(1'b0, 2'd0, 2'd0, 4'd0, "hold_lw");
    hold = 1'b1;
    set_id(1'b1, 5'd4, 5'd1, 5'd14, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) chk(1'b1, 2'd0, 2'd0, CNT_W'(i), "hold_stall");
    hold = 1'b0;
    chk(1'b1, 2'd0, 2'd0, 4'd4, "hold_release");
    chk(1'b0, 2'd2, 2'd0, 4'd5, "hold_fwd");

    // Saturating counter, then mid-operation reset clears entries and count
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1);  chk(1'b0, 2'd0, 2'd0, 4'd0, "sat_lw");
    hold = 1'b1;
    set_id(1'b1, 5'd4, 5'd4, 5'd15, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) chk(1'b1, 2'd0, 2'd0, CNT_W'((i >= 15) ? 15 : i), "sat_stall");
    hold = 1'b0;
    set_id(1'b0, '0, '0, '0, 1'b0, 1'b0);        chk(1'b0, 2'd0, 2'd0, 4'd15, "sat_hold");
    set_id(1'b1, 5'd4, 5'd4, 5'd16, 1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk(1'b0, 2'd0, 2'd0, 4'd0, "reset_clears");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
